// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - ARM7 memory-access stage sequencing single and block transfers into data_cache
// Optional ROTATE_UNALIGNED_EN: unaligned word loads return mem_rdata rotated right by 8*addr[1:0].

module load_store_unit #(
   parameter int N      = 32,
   parameter int NREGS  = 16,
   parameter int RIDX_W = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              op_load,
   input  logic              op_byte,
   input  logic              op_block,
   input  logic              blk_up,
   input  logic              blk_pre,
   input  logic [N-1:0]      addr,
   input  logic [RIDX_W-1:0] rd_idx,
   input  logic [NREGS-1:0]  reg_list,
   output logic [RIDX_W-1:0] rf_read_idx,
   input  logic [N-1:0]      rf_read_data,
   output logic              rf_write_en,
   output logic [RIDX_W-1:0] rf_write_idx,
   output logic [N-1:0]      rf_write_data,
   output logic              wb_base_en,
   output logic [N-1:0]      wb_base_data,
   output logic              done,
   output logic [N-1:0]      mem_address,
   output logic [N-1:0]      mem_wdata,
   input  logic [N-1:0]      mem_rdata,
   output logic              mem_read_enable,
   output logic              mem_write_enable,
   output logic              mem_isByte
);

   localparam int CNT_W = $clog2(NREGS + 1);

   // One-hot so each cache strobe decodes from a single state bit plus a stable op flag.
   typedef enum logic [5:0] {
      S_IDLE    = 6'b000001,
      S_SETUP   = 6'b000010,
      S_ADDR    = 6'b000100,
      S_STROBE  = 6'b001000,
      S_CAPTURE = 6'b010000,
      S_DONE    = 6'b100000
   } state_t;

   state_t           state_q, state_d;
   logic             load_q, load_d;
   logic             byte_q, byte_d;
   logic             block_q, block_d;
   logic             up_q, up_d;
   logic             pre_q, pre_d;
   logic [N-1:0]     base_q, base_d;
   logic [N-1:0]     addr_q, addr_d;
   logic [N-1:0]     new_base_q, new_base_d;
   logic [N-1:0]     wdata_q, wdata_d;
   logic [NREGS-1:0] mask_q, mask_d;

   logic [CNT_W-1:0]  cnt;
   logic [RIDX_W-1:0] cur_idx;
   logic [NREGS-1:0]  mask_rest;
   logic [N-1:0]      four_n;
   logic [N-1:0]      base_al;
   logic [N-1:0]      store_data;
   logic [N-1:0]      byte_load;
   logic [N-1:0]      load_data;

   // Remaining-beat mask: its population is n, its lowest set bit is the current register.
   always_comb begin
      cnt     = '0;
      cur_idx = '0;
      for (int i = NREGS - 1; i >= 0; i--) begin
         if (mask_q[i]) begin
            cnt     = cnt + CNT_W'(1);
            cur_idx = RIDX_W'(i);
         end
      end
   end

   assign mask_rest  = mask_q & (mask_q - NREGS'(1));
   assign four_n     = N'(cnt) << 2;
   assign base_al    = {base_q[N-1:2], 2'b00};
   assign store_data = byte_q ? {{(N-8){1'b0}}, rf_read_data[7:0]} : rf_read_data;
   assign byte_load  = {{(N-8){1'b0}}, mem_rdata[7:0]};

`ifdef ROTATE_UNALIGNED_EN
   localparam int SH_W = $clog2(N) + 1;
   logic [SH_W-1:0] rot_sh;
   logic [N-1:0]    rot_data;
   assign rot_sh    = SH_W'({addr_q[1:0], 3'b000});
   assign rot_data  = (mem_rdata >> rot_sh) | (mem_rdata << (SH_W'(N) - rot_sh));
   assign load_data = byte_q ? byte_load : rot_data;
`else
   assign load_data = byte_q ? byte_load : mem_rdata;
`endif

   always_comb begin
      state_d    = state_q;
      load_d     = load_q;
      byte_d     = byte_q;
      block_d    = block_q;
      up_d       = up_q;
      pre_d      = pre_q;
      base_d     = base_q;
      addr_d     = addr_q;
      new_base_d = new_base_q;
      wdata_d    = wdata_q;
      mask_d     = mask_q;

      req_ready        = 1'b0;
      rf_read_idx      = '0;
      rf_write_en      = 1'b0;
      rf_write_idx     = '0;
      rf_write_data    = '0;
      wb_base_en       = 1'b0;
      wb_base_data     = '0;
      done             = 1'b0;
      mem_address      = '0;
      mem_wdata        = '0;
      mem_read_enable  = 1'b0;
      mem_write_enable = 1'b0;
      mem_isByte       = 1'b0;

      case (state_q)
         S_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               load_d  = op_load;
               byte_d  = op_byte & ~op_block;
               block_d = op_block;
               up_d    = blk_up;
               pre_d   = blk_pre;
               base_d  = addr;
               mask_d  = op_block ? reg_list : (NREGS'(1) << rd_idx);
               state_d = S_SETUP;
            end
         end
         S_SETUP: begin
            if (block_q) begin
               case ({up_q, pre_q})
                  2'b10:   addr_d = base_al;
                  2'b11:   addr_d = base_al + N'(4);
                  2'b00:   addr_d = base_al - four_n + N'(4);
                  default: addr_d = base_al - four_n;
               endcase
               new_base_d = up_q ? (base_q + four_n) : (base_q - four_n);
               state_d    = (mask_q == '0) ? S_DONE : S_ADDR;
            end else begin
               addr_d  = base_q;
               state_d = S_ADDR;
            end
         end
         S_ADDR: begin
            mem_address = addr_q;
            mem_isByte  = byte_q;
            if (!load_q) begin
               rf_read_idx = cur_idx;
               mem_wdata   = store_data;
               wdata_d     = store_data;
            end
            state_d = S_STROBE;
         end
         S_STROBE: begin
            mem_address      = addr_q;
            mem_isByte       = byte_q;
            mem_wdata        = load_q ? '0 : wdata_q;
            mem_read_enable  = load_q;
            mem_write_enable = ~load_q;
            state_d          = S_CAPTURE;
         end
         S_CAPTURE: begin
            if (load_q) begin
               rf_write_en   = 1'b1;
               rf_write_idx  = cur_idx;
               rf_write_data = load_data;
            end
            mask_d  = mask_rest;
            addr_d  = addr_q + N'(4);
            state_d = (mask_rest == '0) ? S_DONE : S_ADDR;
         end
         S_DONE: begin
            done         = 1'b1;
            wb_base_en   = block_q;
            wb_base_data = block_q ? new_base_q : '0;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         load_q     <= 1'b0;
         byte_q     <= 1'b0;
         block_q    <= 1'b0;
         up_q       <= 1'b0;
         pre_q      <= 1'b0;
         base_q     <= '0;
         addr_q     <= '0;
         new_base_q <= '0;
         wdata_q    <= '0;
         mask_q     <= '0;
      end else begin
         state_q    <= state_d;
         load_q     <= load_d;
         byte_q     <= byte_d;
         block_q    <= block_d;
         up_q       <= up_d;
         pre_q      <= pre_d;
         base_q     <= base_d;
         addr_q     <= addr_d;
         new_base_q <= new_base_d;
         wdata_q    <= wdata_d;
         mask_q     <= mask_d;
      end
   end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a transfer-level memory/register model

module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        reset, req_valid, req_ready, op_load, op_byte, op_block, blk_up, blk_pre;
   logic [31:0] addr;
   logic [3:0]  rd_idx;
   logic [15:0] reg_list;
   logic [3:0]  rf_read_idx, rf_write_idx;
   logic [31:0] rf_read_data, rf_write_data, wb_base_data;
   logic        rf_write_en, wb_base_en, done;
   logic [31:0] mem_address, mem_wdata;
   logic [31:0] mem_rdata = '0;
   logic        mem_read_enable, mem_write_enable, mem_isByte;

   logic [31:0] cache_mem [1024];
   logic [31:0] model_mem [1024];
   logic [31:0] rf [16];
   logic [31:0] model_rf [16];

   typedef struct {
      bit          is_done;
      logic [3:0]  idx;
      logic [31:0] data;
      bit          wb_en;
      logic [31:0] wb_data;
      int          acc;
      int          lat;
   } exp_t;

   exp_t exp_q[$];
   int   tests = 0, fails = 0, cyc = 0, en_cnt = 0, done_cnt = 0;
   bit   prev_en = 1'b0;

   always #5 clk = ~clk;

   assign rf_read_data = rf[rf_read_idx];

   load_store_unit dut (
      .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
      .op_load(op_load), .op_byte(op_byte), .op_block(op_block), .blk_up(blk_up), .blk_pre(blk_pre),
      .addr(addr), .rd_idx(rd_idx), .reg_list(reg_list),
      .rf_read_idx(rf_read_idx), .rf_read_data(rf_read_data),
      .rf_write_en(rf_write_en), .rf_write_idx(rf_write_idx), .rf_write_data(rf_write_data),
      .wb_base_en(wb_base_en), .wb_base_data(wb_base_data), .done(done),
      .mem_address(mem_address), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
      .mem_read_enable(mem_read_enable), .mem_write_enable(mem_write_enable), .mem_isByte(mem_isByte)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

`ifdef ROTATE_UNALIGNED_EN
   function automatic logic [31:0] rotr(input logic [31:0] x, input int s);
      return (x >> s) | (x << (32 - s));
   endfunction
`endif

   always @(posedge clk) cyc <= cyc + 1;

   // Cache model plus output monitor: strobes act on the cache, outputs are popped against the scoreboard.
   always @(negedge clk) begin : monitor
      exp_t        e;
      logic [31:0] w, junk;
      if (!reset) begin
         if (mem_read_enable || mem_write_enable) begin
            en_cnt++;
            chk("enable_gap", {31'b0, prev_en}, 32'd0);
            chk("single_enable", {31'b0, mem_read_enable & mem_write_enable}, 32'd0);
         end
         prev_en = mem_read_enable | mem_write_enable;
         if (mem_read_enable) begin
            w = cache_mem[mem_address[11:2]];
            if (mem_isByte) begin
               junk      = $urandom;
               mem_rdata = {junk[31:8], w[8*mem_address[1:0] +: 8]};
            end else begin
               mem_rdata = w;
            end
         end
         if (mem_write_enable) begin
            w = cache_mem[mem_address[11:2]];
            if (mem_isByte) begin
               chk("strb_upper_zero", {8'h0, mem_wdata[31:8]}, 32'd0);
               w[8*mem_address[1:0] +: 8] = mem_wdata[7:0];
            end else begin
               w = mem_wdata;
            end
            cache_mem[mem_address[11:2]] = w;
         end
         if (rf_write_en) begin
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_rf_write: idx %0d data %h, none expected", rf_write_idx, rf_write_data);
            end else begin
               e = exp_q.pop_front();
               chk("rf_write_kind", {31'b0, e.is_done}, 32'd0);
               chk("rf_write_idx", {28'b0, rf_write_idx}, {28'b0, e.idx});
               chk("rf_write_data", rf_write_data, e.data);
            end
            rf[rf_write_idx] = rf_write_data;
         end
         if (done) begin
            done_cnt++;
            if (exp_q.size() == 0) begin
               tests++; fails++;
               $display("FAIL unexpected_done: got done expected none");
            end else begin
               e = exp_q.pop_front();
               chk("done_kind", {31'b0, e.is_done}, 32'd1);
               chk("wb_base_en", {31'b0, wb_base_en}, {31'b0, e.wb_en});
               chk("wb_base_data", wb_base_data, e.wb_data);
               chk("latency", cyc - e.acc, e.lat);
               chk("ready_busy", {31'b0, req_ready}, 32'd0);
            end
         end else if (wb_base_en) begin
            tests++; fails++;
            $display("FAIL stray_wb_base_en: got 1 expected 0");
         end
      end
   end

   task automatic wait_ready(output bit ok);
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         ok = req_ready;
      end
      if (!ok) begin
         tests++; fails++;
         $display("FAIL wait_ready: req_ready got 0 expected 1 within 50 cycles");
      end
   endtask

   task automatic issue(input bit ld, input bit byt, input bit blk, input bit up, input bit pre,
                        input logic [31:0] a, input logic [3:0] rd, input logic [15:0] rl);
      logic [31:0] start, b, wbv, v, w, ea;
      logic [3:0]  regs[$];
      int          n, acc, en0, d0;
      bit          ok;
      exp_t        e;
      wait_ready(ok);
      if (!ok) return;
      acc = cyc; en0 = en_cnt; d0 = done_cnt;
      if (blk) begin
         for (int r = 0; r < 16; r++) if (rl[r]) regs.push_back(4'(r));
         n = regs.size();
         b = {a[31:2], 2'b00};
         if (up) start = pre ? b + 4 : b;
         else    start = pre ? b - 4 * n : b - 4 * n + 4;
         wbv = up ? a + 4 * n : a - 4 * n;
      end else begin
         regs.push_back(rd);
         n = 1; start = a; wbv = '0;
      end
      for (int k = 0; k < n; k++) begin
         ea = blk ? start + 4 * k : a;
         w  = model_mem[ea[11:2]];
         if (ld) begin
            if (byt && !blk) begin
               v = {24'h0, w[8*ea[1:0] +: 8]};
            end else begin
               v = w;
`ifdef ROTATE_UNALIGNED_EN
               v = rotr(w, 8 * ea[1:0]);
`endif
            end
            model_rf[regs[k]] = v;
            e = '{1'b0, regs[k], v, 1'b0, 32'h0, 0, 0};
            exp_q.push_back(e);
         end else begin
            if (byt && !blk) w[8*ea[1:0] +: 8] = model_rf[regs[k]][7:0];
            else             w = model_rf[regs[k]];
            model_mem[ea[11:2]] = w;
         end
      end
      e = '{1'b1, 4'h0, 32'h0, blk, wbv, acc, 2 + 3 * n};
      exp_q.push_back(e);
      op_load = ld; op_byte = byt; op_block = blk; blk_up = up; blk_pre = pre;
      addr = a; rd_idx = rd; reg_list = rl; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      ok = 1'b0;
      for (int t = 0; t < 100 && !ok; t++) begin
         @(negedge clk);
         #1;
         if (done_cnt != d0) ok = 1'b1;
      end
      if (!ok) begin
         tests++; fails++;
         $display("FAIL done_timeout: done got 0 expected 1 within 100 cycles");
         exp_q.delete();
      end else begin
         chk("enable_pulses", en_cnt - en0, n);
      end
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          bad, acc;
      bit          ok;
      logic [23:0] nb;
      exp_t        e;
      reset = 1'b1; req_valid = 1'b0; op_load = 1'b0; op_byte = 1'b0; op_block = 1'b0;
      blk_up = 1'b0; blk_pre = 1'b0; addr = '0; rd_idx = '0; reg_list = '0;
      for (int i = 0; i < 1024; i++) begin
         cache_mem[i] = $urandom;
         model_mem[i] = cache_mem[i];
      end
      for (int i = 0; i < 16; i++) begin
         rf[i] = $urandom;
         model_rf[i] = rf[i];
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("reset_ready", {31'b0, req_ready}, 32'd1);
      chk("reset_strobes", {26'b0, mem_read_enable, mem_write_enable, done, rf_write_en, wb_base_en, mem_isByte}, 32'd0);
      chk("reset_mem_address", mem_address, 32'd0);
      chk("reset_wb_base_data", wb_base_data, 32'd0);
      reset = 1'b0;

      rf[3] = 32'hDEADBEEF; model_rf[3] = 32'hDEADBEEF;
      issue(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 4'd3, 16'h0);
      issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h100, 4'd5, 16'h0);
      chk("ldr_r5", rf[5], 32'hDEADBEEF);

      rf[1] = 32'h123456A7; model_rf[1] = 32'h123456A7;
      nb = cache_mem[10'h080][23:0];
      issue(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h203, 4'd1, 16'h0);
      issue(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'h203, 4'd2, 16'h0);
      chk("ldrb_r2", rf[2], 32'h000000A7);
      chk("strb_neighbours", {8'h0, cache_mem[10'h080][23:0]}, {8'h0, nb});

      issue(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h400, 4'd0, 16'h000E);
      chk("stmdb_r1", cache_mem[10'h0FD], 32'h123456A7);
      chk("stmdb_r2", cache_mem[10'h0FE], 32'h000000A7);
      chk("stmdb_r3", cache_mem[10'h0FF], 32'hDEADBEEF);

      for (int r = 1; r <= 3; r++) begin
         rf[r] = $urandom;
         model_rf[r] = rf[r];
      end
      issue(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3F4, 4'd0, 16'h000E);
      chk("ldmia_r1", rf[1], 32'h123456A7);
      chk("ldmia_r2", rf[2], 32'h000000A7);
      chk("ldmia_r3", rf[3], 32'hDEADBEEF);
      issue(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h3F4, 4'd0, 16'h0000);

      // Reset lands on the read strobe of the second beat of a three-register LDMIA.
      wait_ready(ok);
      acc = cyc;
      model_rf[1] = model_mem[10'h0FD];
      e = '{1'b0, 4'd1, model_mem[10'h0FD], 1'b0, 32'h0, 0, 0};
      exp_q.push_back(e);
      op_load = 1'b1; op_byte = 1'b0; op_block = 1'b1; blk_up = 1'b1; blk_pre = 1'b0;
      addr = 32'h3F4; reg_list = 16'h000E; req_valid = 1'b1;
      @(posedge clk);
      #1 req_valid = 1'b0;
      for (int t = 0; t < 20 && cyc < acc + 6; t++) @(negedge clk);
      chk("abort_at_strobe", {31'b0, mem_read_enable}, 32'd1);
      #1 reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      #1;
      chk("abort_ready", {31'b0, req_ready}, 32'd1);
      chk("abort_outputs", {27'b0, mem_read_enable, mem_write_enable, done, rf_write_en, wb_base_en}, 32'd0);
      reset = 1'b0;
      repeat (15) @(negedge clk);
      chk("abort_scoreboard_empty", exp_q.size(), 32'd0);

      cache_mem[10'h140] = 32'h11223344; model_mem[10'h140] = 32'h11223344;
      issue(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h501, 4'd4, 16'h0);
`ifdef ROTATE_UNALIGNED_EN
      chk("ldr_unaligned", rf[4], 32'h44112233);
`else
      chk("ldr_unaligned", rf[4], 32'h11223344);
`endif

      for (int i = 0; i < 60; i++) begin
         bit          ld, byt, blk, up, pre;
         logic [31:0] a;
         logic [15:0] rl;
         blk = ($urandom_range(0, 2) == 0);
         ld  = 1'($urandom_range(0, 1));
         byt = 1'($urandom_range(0, 1));
         up  = 1'($urandom_range(0, 1));
         pre = 1'($urandom_range(0, 1));
         rl  = ($urandom_range(0, 5) == 0) ? 16'h0 : 16'($urandom);
         a   = blk ? $urandom_range(32'h100, 32'hE00) : $urandom_range(0, 32'hFFF);
         issue(ld, byt, blk, up, pre, a, 4'($urandom), rl);
      end

      repeat (5) @(negedge clk);
      chk("final_scoreboard_empty", exp_q.size(), 32'd0);
      bad = 0;
      for (int i = 0; i < 1024; i++) if (cache_mem[i] !== model_mem[i]) bad++;
      chk("memory_image", bad, 32'd0);
      bad = 0;
      for (int i = 0; i < 16; i++) if (rf[i] !== model_rf[i]) bad++;
      chk("register_file", bad, 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-access stage of the ARM7 core; sits directly upstream of data_cache.
- Accepts one load/store request from execute: single LDR/STR/LDRB/STRB, or block LDM/STM.
- Sequences the cache's edge-triggered read_enable/write_enable strobes, reads store data from the register file and writes load results back.
- Returns the updated base register for block transfers.

Parameters:
- N, 32, data/address width.
- NREGS, 16, register-file entries; reg_list width.
- RIDX_W, 4, register index width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle, can accept.
- op_load  input  1  1=load, 0=store.
- op_byte  input  1  byte transfer (single only; ignored for block).
- op_block  input  1  1=LDM/STM, 0=single.
- blk_up  input  1  block: increment (U).
- blk_pre  input  1  block: pre-index (P).
- addr  input  N  single: effective address; block: base value.
- rd_idx  input  RIDX_W  single: source/destination register.
- reg_list  input  NREGS  block: register mask.
- rf_read_idx  output  RIDX_W  register-file read index (combinational read).
- rf_read_data  input  N  register-file read data.
- rf_write_en  output  1  load-result write strobe.
- rf_write_idx  output  RIDX_W  write index.
- rf_write_data  output  N  write data.
- wb_base_en  output  1  block base-writeback strobe.
- wb_base_data  output  N  new base value.
- done  output  1  one-cycle completion pulse.
- mem_address  output  N  to data_cache data_address.
- mem_wdata  output  N  to data_cache in_data.
- mem_rdata  input  N  from data_cache out_data.
- mem_read_enable  output  1  to data_cache read_enable.
- mem_write_enable  output  1  to data_cache write_enable.
- mem_isByte  output  1  to data_cache isByte.

Behaviour:
- Reset: state IDLE; req_ready=1; all other outputs 0, including both mem enables.
- Reset mid-operation: return to IDLE the next cycle; enables drop to 0; no rf or wb write.
- States: IDLE, SETUP, ADDR, STROBE, CAPTURE, DONE.
- IDLE: req_ready=1. Request accepted when req_valid && req_ready; latch all request fields; go to SETUP. req_ready=0 in every other state.
- SETUP (1 cycle):
  - Compute n = popcount(reg_list) (block) or n=1 (single).
  - Block start address, with base[1:0] forced to 0:
    - IA (U=1,P=0): base
    - IB (U=1,P=1): base+4
    - DA (U=0,P=0): base-4n+4
    - DB (U=0,P=1): base-4n
  - new_base = U ? base+4n : base-4n, computed modulo 2^N.
  - Block with n=0: go directly to DONE, no memory activity, wb_base_data = base.
- Per beat (ADDR → STROBE → CAPTURE):
  - ADDR: drive mem_address and mem_isByte, both enables 0. For stores, drive rf_read_idx and register rf_read_data into mem_wdata.
  - STROBE: raise exactly one enable (read for load, write for store). Address, data and isByte are held unchanged from ADDR.
  - CAPTURE: enables 0. For loads: rf_write_en=1, rf_write_idx = current register, rf_write_data = processed mem_rdata.
  - Next state: ADDR for the next beat (address+4, next-higher set bit of reg_list) or DONE after the last beat.
- Block order: lowest register index goes to lowest address, regardless of U/P.
- Byte load: rf_write_data = {24'h0, mem_rdata[7:0]}; the cache's undriven upper bits are never propagated. Byte store: mem_wdata = {24'h0, rd[7:0]}; mem_isByte=1.
- Single word accesses use addr unmodified; block accesses are always word-aligned.
- DONE (1 cycle): done=1. For block: wb_base_en=1, wb_base_data=new_base. Then IDLE.
- wb_base_en is asserted for every block transfer; upstream decides whether to commit it.
- Latency: accept edge to done = 2+3n cycles. Single transfer = 5 cycles. Enables never high in consecutive cycles, so every beat produces a fresh rising edge.
- Outputs are held at 0 when not in the states above that drive them.

Optional Feature:
- ROTATE_UNALIGNED_EN defined: word load with addr[1:0]≠0 returns mem_rdata rotated right by 8*addr[1:0] (ARM7 semantics). mem_address is still sent unmodified.
- Not defined: no rotation; rf_write_data = mem_rdata.

Test Plan:
- Single STR r3=0xDEADBEEF at 0x100, then LDR r5 from 0x100 → r5=0xDEADBEEF; done 5 cycles after each accept; req_ready low for 5 cycles.
- STRB r1=0x123456A7 at 0x203, then LDRB r2 from 0x203 → r2=0x000000A7; neighbouring bytes 0x200–0x202 unchanged.
- STMDB base=0x400, reg_list=0x000E (r1,r2,r3) → r1@0x3F4, r2@0x3F8, r3@0x3FC; wb_base_data=0x3F4; done at cycle 11.
- LDMIA base=0x3F4, reg_list=0x000E → r1,r2,r3 restored in 3 rf writes at idx 1,2,3; wb_base_data=0x400; empty reg_list → done at cycle 2, wb_base_data=base, no enable pulse.
- Assert reset during STROBE of beat 2 of a 3-register LDM → next cycle IDLE, req_ready=1, all enables 0, no further rf_write_en, no wb_base_en.
- With ROTATE_UNALIGNED_EN: word 0x11223344 at 0x500, LDR from 0x501 → 0x44112233. Without the macro → returned unmodified as the cache's word at 0x501.
